// File: rtl/uart_rx_fifo.sv
// Byte FIFO from uart_rx to the ioexp transponder, with RTS hysteresis and a four-phase offer handshake.
// Optional dropped-byte counter enabled by defining UART_RX_FIFO_STATS_EN.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned RTS_HI     = 12,
    parameter int unsigned RTS_LO     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  rts_n,
    output logic [7:0]            tx_data,
    output logic                  tx_data_available,
    input  logic                  tx_data_ack_n,
    output logic [DEPTH_LOG2:0]   level,
    output logic [7:0]            ovf_count
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  full_c, pop_c, push_c;
    logic                  avail_nxt;
    logic [7:0]            tx_data_nxt;
    logic [LW-1:0]         level_nxt;

    assign full_c = (level == LW'(DEPTH));
    // A full FIFO still accepts a byte when the same cycle frees a slot.
    assign push_c = in_valid && (!full_c || pop_c);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Handshake sequencing; the pop happens only on OFFER->RELEASE.
    always_comb begin
        state_nxt   = state;
        avail_nxt   = 1'b0;
        tx_data_nxt = tx_data;
        pop_c       = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0 && tx_data_ack_n) begin
                    tx_data_nxt = mem[rd_ptr];
                    avail_nxt   = 1'b1;
                    state_nxt   = OFFER;
                end
            end
            OFFER: begin
                avail_nxt = 1'b1;
                if (!tx_data_ack_n) begin
                    pop_c     = 1'b1;
                    avail_nxt = 1'b0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (tx_data_ack_n) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        level_nxt = level;
        case ({push_c, pop_c})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && push_c) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            level             <= '0;
            rts_n             <= 1'b0;
            tx_data           <= 8'h00;
            tx_data_available <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop_c)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            level             <= level_nxt;
            tx_data           <= tx_data_nxt;
            tx_data_available <= avail_nxt;
            // Hysteresis on the settled fill level, held between the thresholds.
            if (level >= LW'(RTS_HI))      rts_n <= 1'b1;
            else if (level <= LW'(RTS_LO)) rts_n <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_STATS_EN
    logic       drop_c;
    logic [7:0] ovf_q;

    assign drop_c = in_valid && full_c && !pop_c;

    always_ff @(posedge clk) begin
        if (rst)                            ovf_q <= 8'h00;
        else if (drop_c && ovf_q != 8'hFF)  ovf_q <= ovf_q + 8'd1;
    end

    assign ovf_count = ovf_q;
`else
    assign ovf_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed vector table plus handshake sequences and a randomized scoreboard run for uart_rx_fifo.
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       rts_n;
    logic [7:0] tx_data;
    logic       tx_data_available;
    logic       tx_data_ack_n;
    logic [4:0] level;
    logic [7:0] ovf_count;

    uart_rx_fifo dut (
        .clk               (clk),
        .rst               (rst),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .rts_n             (rts_n),
        .tx_data           (tx_data),
        .tx_data_available (tx_data_available),
        .tx_data_ack_n     (tx_data_ack_n),
        .level             (level),
        .ovf_count         (ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ack;
        logic       avail;
        logic [7:0] tx;
        int         lvl;
    } vec_t;

    vec_t     vecs [17];
    int       tests = 0;
    int       fails = 0;
    int       drops = 0;
    logic [7:0] q [$];
    logic     rts_m;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic ack);
        in_valid      = v;
        in_data       = d;
        tx_data_ack_n = ack;
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_ovf();
        return STATS ? ((drops > 255) ? 255 : drops) : 0;
    endfunction

    // One ioexp transaction: wait for the offer, check the byte, ack low then high.
    task automatic handshake();
        logic [7:0] exp_b;
        int         n;
        n = 0;
        while (!tx_data_available && n < 8) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
        end
        chk("hs_offer", int'(tx_data_available), 1);
        exp_b = q.pop_front();
        chk("hs_data", int'(tx_data), int'(exp_b));
        step(1'b0, 8'h00, 1'b0);
        chk("hs_pop_level", int'(level), q.size());
        chk("hs_pop_avail", int'(tx_data_available), 0);
        step(1'b0, 8'h00, 1'b1);
        chk("hs_rts", int'(rts_n), (q.size() > 4) ? 1 : 0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 0};
        vecs[5]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 1};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 0};
        vecs[12] = '{1'b1, 8'h77, 1'b0, 1'b0, 8'h3C, 1};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 1};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h77, 1};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h77, 0};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h77, 0};

        rst = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b1);
        chk("rst_level", int'(level), 0);
        chk("rst_avail", int'(tx_data_available), 0);
        chk("rst_rts", int'(rts_n), 0);
        chk("rst_ovf", int'(ovf_count), 0);

        // Reset in the middle of an offer with five bytes queued.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 8'h50), 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("pre_rst_level", int'(level), 5);
        chk("pre_rst_avail", int'(tx_data_available), 1);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        chk("mid_rst_avail", int'(tx_data_available), 0);
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_rts", int'(rts_n), 0);
        chk("mid_rst_tx", int'(tx_data), 0);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_avail", int'(tx_data_available), 0);

        // Single-byte handshakes, RELEASE hold, ack-low-in-IDLE ignored.
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].ack);
            chk($sformatf("vec%0d_avail", i), int'(tx_data_available), int'(vecs[i].avail));
            chk($sformatf("vec%0d_tx", i), int'(tx_data), int'(vecs[i].tx));
            chk($sformatf("vec%0d_level", i), int'(level), vecs[i].lvl);
            chk($sformatf("vec%0d_rts", i), int'(rts_n), 0);
        end

        // Fill to 16 without acks; rts follows one cycle after level hits 12.
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 8'(k - 1), 1'b1);
            q.push_back(8'(k - 1));
            chk($sformatf("fill%0d_level", k), int'(level), k);
            chk($sformatf("fill%0d_rts", k), int'(rts_n), (k >= 13) ? 1 : 0);
        end
        step(1'b1, 8'hEE, 1'b1);
        drops++;
        chk("ovf17_level", int'(level), 16);
        chk("ovf17_ovf", int'(ovf_count), exp_ovf());
        chk("full_avail", int'(tx_data_available), 1);
        chk("full_tx", int'(tx_data), 0);

        // Push while full, coincident with the pop.
        step(1'b1, 8'h10, 1'b0);
        void'(q.pop_front());
        q.push_back(8'h10);
        chk("pp_level", int'(level), 16);
        chk("pp_avail", int'(tx_data_available), 0);
        chk("pp_ovf", int'(ovf_count), exp_ovf());
        step(1'b0, 8'h00, 1'b1);

        // Drain in order while watching rts hysteresis.
        for (int k = 0; k < 16; k++) handshake();
        chk("drain_level", int'(level), 0);
        chk("drain_rts", int'(rts_n), 0);

        // Random traffic against a queue model across pointer wraps.
        rts_m = rts_n;
        for (int i = 0; i < 10000; i++) begin
            logic       v, ack, pop_m;
            logic [7:0] d;
            int         lvl_before;
            v   = (i < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            d   = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 2) != 0);
            pop_m = tx_data_available && !ack;
            lvl_before = q.size();
            if (pop_m) begin
                logic [7:0] b;
                b = q.pop_front();
                chk("rnd_data", int'(tx_data), int'(b));
            end
            if (v) begin
                if (lvl_before == 16 && !pop_m) drops++;
                else q.push_back(d);
            end
            if (lvl_before >= 12)     rts_m = 1'b1;
            else if (lvl_before <= 4) rts_m = 1'b0;
            step(v, d, ack);
            chk("rnd_level", int'(level), q.size());
            chk("rnd_rts", int'(rts_n), int'(rts_m));
            chk("rnd_ovf", int'(ovf_count), exp_ovf());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
